// File: rtl/fp_pkg.sv
// Shared widths, the unpacked-operand struct and the unpack helper for the FP adder.
// FP_ALIGN_DENORM_EN selects gradual-underflow alignment; by default denormals flush to zero.
package fp_pkg;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int GRS_W   = 3;
    localparam int SIG_W   = MAN_W + 1;
    localparam int ALIGN_W = SIG_W + GRS_W;
    localparam int SH_W    = $clog2(ALIGN_W + 1);
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_op_t;

    function automatic fp_op_t unpack(input logic [EXP_W+MAN_W:0] x);
        fp_op_t           o;
        logic [EXP_W-1:0] e;
        e      = x[EXP_W+MAN_W-1:MAN_W];
        o.sign = x[EXP_W+MAN_W];
`ifdef FP_ALIGN_DENORM_EN
        // Denormals sit at effective exponent 1 with no hidden bit.
        o.exp = (e == '0) ? EXP_W'(1) : e;
        o.sig = {(e != '0), x[MAN_W-1:0]};
`else
        o.exp = e;
        o.sig = (e == '0) ? '0 : {1'b1, x[MAN_W-1:0]};
`endif
        return o;
    endfunction
endpackage

// File: rtl/comparator_24bit.sv
// Unsigned magnitude comparator for significands: l = a < b, e = a == b.
module comparator_24bit #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         l,
    output logic         e
);
    assign l = (a < b);
    assign e = (a == b);
endmodule

// File: rtl/fp_align_stage.sv
// Operand ordering and exponent alignment for the FP adder: stage 1 compares/swaps,
// stage 2 right-shifts the smaller significand with G/R/S. Honours FP_ALIGN_DENORM_EN.
module fp_align_stage
    import fp_pkg::*;
#(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int MAN_W = fp_pkg::MAN_W,
    parameter int GRS_W = fp_pkg::GRS_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_i,
    input  logic [EXP_W+MAN_W:0]   b_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   big_sign_o,
    output logic [EXP_W-1:0]       big_exp_o,
    output logic [MAN_W+GRS_W:0]   big_man_o,
    output logic [MAN_W+GRS_W:0]   small_man_o,
    output logic                   eff_sub_o,
    output logic                   swapped_o,
    output logic                   zero_o,
    output logic                   special_o
);
    localparam int SW = MAN_W + 1;
    localparam int AW = MAN_W + 1 + GRS_W;

    logic [2:1] vld_pipe;
    logic       s1_adv, s2_adv;

    assign s2_adv    = ~vld_pipe[2] | out_ready;
    assign s1_adv    = ~vld_pipe[1] | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];

    // Stage 1: unpack, compare, order
    fp_op_t op_a, op_b, op_big, op_small;
    logic   sig_lt, sig_eq, swap, exp_eq;

    assign op_a = unpack(a_i);
    assign op_b = unpack(b_i);

    comparator_24bit #(.W(SW)) u_cmp (
        .a (op_a.sig),
        .b (op_b.sig),
        .l (sig_lt),
        .e (sig_eq)
    );

    assign exp_eq   = (op_a.exp == op_b.exp);
    assign swap     = (op_b.exp > op_a.exp) || (exp_eq && sig_lt);
    assign op_big   = swap ? op_b : op_a;
    assign op_small = swap ? op_a : op_b;

    logic             s1_big_sign, s1_eff_sub, s1_swapped, s1_zero, s1_special;
    logic [EXP_W-1:0] s1_big_exp, s1_diff;
    logic [SW-1:0]    s1_big_sig, s1_small_sig;

    // Stage 2: align the smaller significand, folding shifted-out bits into S
    logic [SH_W-1:0] sh;
    logic [AW-1:0]   ext, shifted, aligned;
    logic            lost;

    always_comb begin
        sh = '0;
        if (!s1_special)
            sh = (s1_diff > EXP_W'(AW)) ? SH_W'(AW) : s1_diff[SH_W-1:0];
        ext     = {s1_small_sig, {GRS_W{1'b0}}};
        shifted = ext >> sh;
        lost    = |(ext & ~({AW{1'b1}} << sh));
        aligned = {shifted[AW-1:1], shifted[0] | lost};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe     <= '0;
            s1_big_sign  <= 1'b0;
            s1_big_exp   <= '0;
            s1_big_sig   <= '0;
            s1_small_sig <= '0;
            s1_diff      <= '0;
            s1_eff_sub   <= 1'b0;
            s1_swapped   <= 1'b0;
            s1_zero      <= 1'b0;
            s1_special   <= 1'b0;
            big_sign_o   <= 1'b0;
            big_exp_o    <= '0;
            big_man_o    <= '0;
            small_man_o  <= '0;
            eff_sub_o    <= 1'b0;
            swapped_o    <= 1'b0;
            zero_o       <= 1'b0;
            special_o    <= 1'b0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_big_sign  <= op_big.sign;
                    s1_big_exp   <= op_big.exp;
                    s1_big_sig   <= op_big.sig;
                    s1_small_sig <= op_small.sig;
                    s1_diff      <= op_big.exp - op_small.exp;
                    s1_eff_sub   <= op_a.sign ^ op_b.sign;
                    s1_swapped   <= swap;
                    s1_zero      <= (op_a.sign ^ op_b.sign) && exp_eq && sig_eq;
                    s1_special   <= (a_i[EXP_W+MAN_W-1:MAN_W] == EXP_ALL_ONES) ||
                                    (b_i[EXP_W+MAN_W-1:MAN_W] == EXP_ALL_ONES);
                end
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    big_sign_o  <= s1_big_sign;
                    big_exp_o   <= s1_big_exp;
                    big_man_o   <= {s1_big_sig, {GRS_W{1'b0}}};
                    small_man_o <= aligned;
                    eff_sub_o   <= s1_eff_sub;
                    swapped_o   <= s1_swapped;
                    zero_o      <= s1_zero;
                    special_o   <= s1_special;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: ordering, sticky alignment, backpressure and reset.
module tb_fp_align_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_i, b_i;
    logic        out_valid;
    logic        out_ready;
    logic        big_sign_o;
    logic [7:0]  big_exp_o;
    logic [26:0] big_man_o, small_man_o;
    logic        eff_sub_o, swapped_o, zero_o, special_o;

    int checks = 0;
    int errors = 0;

    fp_align_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .big_sign_o  (big_sign_o),
        .big_exp_o   (big_exp_o),
        .big_man_o   (big_man_o),
        .small_man_o (small_man_o),
        .eff_sub_o   (eff_sub_o),
        .swapped_o   (swapped_o),
        .zero_o      (zero_o),
        .special_o   (special_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One pair in, then observe it two cycles after acceptance (out_ready held high).
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        a_i = a; b_i = b; in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
    endtask

    logic [7:0]  hold_exp;
    logic [26:0] hold_small;
    int          sent, got;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_big_man", big_man_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        apply(32'h3F800000, 32'h3F000000, "t1");
        chk("t1_big_exp", big_exp_o, 32'h7F);
        chk("t1_big_man", big_man_o, 32'h4000000);
        chk("t1_small_man", small_man_o, 32'h2000000);
        chk("t1_swapped", swapped_o, 0);
        chk("t1_eff_sub", eff_sub_o, 0);

        apply(32'h3F000000, 32'h3F800000, "t2");
        chk("t2_swapped", swapped_o, 1);
        chk("t2_big_exp", big_exp_o, 32'h7F);
        chk("t2_small_man", small_man_o, 32'h2000000);

        apply(32'h4B800000, 32'h3F800001, "t3a");
        chk("t3a_big_exp", big_exp_o, 32'h97);
        chk("t3a_small_man", small_man_o, 32'h0000005);
        apply(32'h4B800000, 32'h3F800000, "t3b");
        chk("t3b_small_man", small_man_o, 32'h0000004);

        apply(32'h7E800000, 32'h3F800000, "t4a");
        chk("t4a_small_man", small_man_o, 32'h0000001);
        chk("t4a_special", special_o, 0);
        apply(32'h3F800000, 32'hBF800000, "t4b");
        chk("t4b_eff_sub", eff_sub_o, 1);
        chk("t4b_zero", zero_o, 1);
        chk("t4b_swapped", swapped_o, 0);
        chk("t4b_small_man", small_man_o, 32'h4000000);

        // Flushed denormal always loses the swap and aligns to zero
        apply(32'h00400000, 32'hBF800000, "t4c");
        chk("t4c_swapped", swapped_o, 1);
        chk("t4c_big_sign", big_sign_o, 1);
        chk("t4c_small_man", small_man_o, 0);
        chk("t4c_zero", zero_o, 0);

        // Special operand forces a zero shift
        apply(32'h7F800000, 32'h3F800000, "t6s");
        chk("t6s_special", special_o, 1);
        chk("t6s_big_exp", big_exp_o, 32'hFF);
        chk("t6s_small_man", small_man_o, 32'h4000000);

        // Backpressure: a_i exponents 0x80..0x83 against 1.0, diffs 1..4
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid  = (sent < 4);
            a_i = {1'b0, 8'h80 + 8'(sent), 23'h0};
            b_i = 32'h3F800000;
            #1;
            if (cyc == 2) begin
                chk("bp_in_ready_full", in_ready, 0);
                hold_exp = big_exp_o; hold_small = small_man_o;
                chk("bp_hold_first", big_exp_o, 32'h80);
            end
            if (cyc == 3) begin
                chk("bp_stable_exp", big_exp_o, hold_exp);
                chk("bp_stable_small", small_man_o, hold_small);
                chk("bp_stable_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                chk("bp_order_exp", big_exp_o, 32'h80 + got);
                chk("bp_order_small", small_man_o, 32'h4000000 >> (got + 1));
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("bp_all_out", got, 4);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_no_dup", out_valid, 0);

        // Reset with both stages full and output stalled
        out_ready = 1'b0;
        @(negedge clk);
        a_i = 32'h3F800000; b_i = 32'h3F000000; in_valid = 1'b1;
        @(negedge clk);
        a_i = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst6_full", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst6_out_valid", out_valid, 0);
        chk("rst6_big_exp", big_exp_o, 0);
        chk("rst6_big_man", big_man_o, 0);
        chk("rst6_small_man", small_man_o, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst6_in_ready", in_ready, 1);
        chk("rst6_no_ghost", out_valid, 0);
        @(negedge clk);
        chk("rst6_no_ghost2", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
